// File: rtl/multicycle_sequencer.sv
// LEGv8 multicycle control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with memory timeout fault.
// Optional performance counters (CycleCnt/RetireCnt) are enabled by defining SEQ_PERF_CNT_EN.
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16
`ifdef SEQ_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic        Halt,
  input  logic [10:0] Opcode,
  input  logic        Zero,
  input  logic        MemAck,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        IRWrite,
  output logic        RegRead,
  output logic        ALUEn,
  output logic        MemReq,
  output logic        MemWe,
  output logic        RegWrite,
  output logic        Busy,
  output logic        IllegalOp,
  output logic        Fault
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] RetireCnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_LD, C_ST, C_B, C_CBZ, C_CBNZ, C_ILL
  } cls_t;

  state_t     state;
  state_t     boundary;
  cls_t       cls_q;
  cls_t       dec;
  logic [7:0] tmo_cnt;
  logic       halt_q;
  logic       halt_seen;
  logic       tmo_hit;

  always_comb begin
    casez (Opcode)
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: dec = C_R;
      11'b11111000010:                  dec = C_LD;
      11'b11111000000:                  dec = C_ST;
      11'b000101?????:                  dec = C_B;
      11'b10110100???:                  dec = C_CBZ;
      11'b10110101???:                  dec = C_CBNZ;
      default:                          dec = C_ILL;
    endcase
  end

  // Every path back to FETCH goes through here so a pending Halt stops at the boundary.
  assign halt_seen = halt_q | Halt;
  assign boundary  = halt_seen ? S_IDLE : S_FETCH;
  assign tmo_hit   = (tmo_cnt == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cls_q   <= C_R;
      tmo_cnt <= '0;
      halt_q  <= 1'b0;
    end else begin
      halt_q <= halt_seen;
      case (state)
        S_IDLE: begin
          halt_q <= 1'b0;
          if (Start) state <= S_FETCH;
        end
        S_FETCH: begin
          if (MemAck) begin
            tmo_cnt <= '0;
            state   <= S_DECODE;
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            state   <= S_FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          cls_q <= dec;
          if (dec == C_ILL) begin
            state  <= boundary;
            halt_q <= 1'b0;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          case (cls_q)
            C_R:        state <= S_WB;
            C_LD, C_ST: state <= S_MEM;
            default: begin
              state  <= boundary;
              halt_q <= 1'b0;
            end
          endcase
        end
        S_MEM: begin
          if (MemAck) begin
            tmo_cnt <= '0;
            if (cls_q == C_ST) begin
              state  <= boundary;
              halt_q <= 1'b0;
            end else begin
              state <= S_WB;
            end
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            state   <= S_FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_WB: begin
          state  <= boundary;
          halt_q <= 1'b0;
        end
        S_FAULT: begin
          if (Start) begin
            state  <= boundary;
            halt_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage strobes follow the state; ack-qualified strobes fire only in the completing cycle.
  always_comb begin
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    IRWrite   = 1'b0;
    RegRead   = 1'b0;
    ALUEn     = 1'b0;
    MemReq    = 1'b0;
    MemWe     = 1'b0;
    RegWrite  = 1'b0;
    IllegalOp = 1'b0;
    case (state)
      S_FETCH: begin
        MemReq  = 1'b1;
        IRWrite = MemAck;
      end
      S_DECODE: begin
        RegRead = 1'b1;
        if (dec == C_ILL) begin
          IllegalOp = 1'b1;
          PCWrite   = 1'b1;
        end
      end
      S_EXECUTE: begin
        ALUEn = 1'b1;
        case (cls_q)
          C_B:    begin PCSrc = 1'b1;  PCWrite = 1'b1; end
          C_CBZ:  begin PCSrc = Zero;  PCWrite = 1'b1; end
          C_CBNZ: begin PCSrc = ~Zero; PCWrite = 1'b1; end
          default: ;
        endcase
      end
      S_MEM: begin
        MemReq  = 1'b1;
        MemWe   = (cls_q == C_ST);
        PCWrite = (cls_q == C_ST) & MemAck;
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign Busy  = (state != S_IDLE) && (state != S_FAULT);
  assign Fault = (state == S_FAULT);

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      CycleCnt  <= '0;
      RetireCnt <= '0;
    end else begin
      if (Busy) CycleCnt <= CycleCnt + CNT_W'(1);
      if (PCWrite && (state != S_FAULT)) RetireCnt <= RetireCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: per-instruction trace model, per-cycle compare,
// plus hand-computed cycle/strobe counts per instruction.
module tb_multicycle_sequencer;

  localparam int TO = 4;

  localparam logic [10:0] PCW = 11'h400, PSRC = 11'h200, IRW = 11'h100, RR  = 11'h080,
                          ALU = 11'h040, MRQ  = 11'h020, MWE = 11'h010, RW  = 11'h008,
                          BSY = 11'h004, ILL  = 11'h002, FLT = 11'h001, NONE = 11'h000;

  localparam logic [10:0] OP_ADD  = 11'b10001011000, OP_SUB  = 11'b11001011000,
                          OP_AND  = 11'b10001010000, OP_ORR  = 11'b10101010000,
                          OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000,
                          OP_B    = 11'b00010100111, OP_CBZ  = 11'b10110100101,
                          OP_CBNZ = 11'b10110101010, OP_BAD  = 11'b00000000000;

  localparam int K_R = 0, K_LD = 1, K_ST = 2, K_B = 3, K_CBZ = 4, K_CBNZ = 5, K_ILL = 6;

  logic        clk, rst_n, Start, Halt, Zero, MemAck;
  logic [10:0] Opcode;
  logic        PCWrite, PCSrc, IRWrite, RegRead, ALUEn, MemReq, MemWe, RegWrite;
  logic        Busy, IllegalOp, Fault;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] CycleCnt, RetireCnt;
`endif

  multicycle_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Halt(Halt), .Opcode(Opcode), .Zero(Zero),
    .MemAck(MemAck), .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .RegRead(RegRead),
    .ALUEn(ALUEn), .MemReq(MemReq), .MemWe(MemWe), .RegWrite(RegWrite), .Busy(Busy),
    .IllegalOp(IllegalOp), .Fault(Fault)
`ifdef SEQ_PERF_CNT_EN
    , .CycleCnt(CycleCnt), .RetireCnt(RetireCnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rstn;
    logic        start;
    logic        halt;
    logic        ack;
    logic        z;
    logic [10:0] op;
    logic [10:0] exp;
  } rec_t;

  typedef struct {
    string  name;
    longint got;
    longint exp;
  } pin_t;

  rec_t        q[$];
  pin_t        pins[$];
  int          vectors = 0, miscompares = 0;
  int          busy_n = 0, pcw_n = 0, rw_n = 0, ncyc = 0;
  int          lc = 0, cur_hc = -1;
  logic        chk_cur = 1'b0;
  logic [10:0] exp_cur = '0;

  // Compare process: checks every driven cycle and any queued count checks.
  initial begin
    logic [10:0] got;
    pin_t        p;
    forever begin
      @(negedge clk);
      if (chk_cur) begin
        got = {PCWrite, PCSrc, IRWrite, RegRead, ALUEn, MemReq, MemWe, RegWrite, Busy,
               IllegalOp, Fault};
        vectors++;
        if (got !== exp_cur) begin
          miscompares++;
          $display("FAIL cycle %0d outputs got %b exp %b (PCW PCSrc IRW RR ALU MReq MWe RW Busy Ill Flt)",
                   ncyc, got, exp_cur);
        end
        if (Busy === 1'b1) busy_n++;
        if (PCWrite === 1'b1) pcw_n++;
        if (RegWrite === 1'b1) rw_n++;
      end
      while (pins.size() > 0) begin
        p = pins.pop_front();
        vectors++;
        if (p.got != p.exp) begin
          miscompares++;
          $display("FAIL %s got %0d exp %0d", p.name, p.got, p.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", ncyc);
    $fatal(1, "watchdog");
  end

  function automatic int kind(input logic [10:0] op);
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return K_R;
    if (op == OP_LDUR) return K_LD;
    if (op == OP_STUR) return K_ST;
    if (op[10:5] == 6'b000101) return K_B;
    if (op[10:3] == 8'b10110100) return K_CBZ;
    if (op[10:3] == 8'b10110101) return K_CBNZ;
    return K_ILL;
  endfunction

  task automatic pin(input string nm, input longint got, input longint exp);
    pins.push_back('{nm, got, exp});
  endtask

  task automatic put(input logic rstn, input logic st, input logic h, input logic ack,
                     input logic z, input logic [10:0] op, input logic [10:0] exp);
    q.push_back('{rstn, st, h | (lc == cur_hc), ack, z, op, exp});
    lc++;
  endtask

  task automatic run();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(posedge clk);
      #1;
      rst_n   = r.rstn;
      Start   = r.start;
      Halt    = r.halt;
      MemAck  = r.ack;
      Zero    = r.z;
      Opcode  = r.op;
      exp_cur = r.exp;
      chk_cur = 1'b1;
      ncyc++;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic st);
    for (int i = 0; i < n; i++) put(1'b1, st, 1'b0, 1'b0, 1'b0, OP_ADD, NONE);
    run();
  endtask

  // Builds one instruction's expected trace from its class and wait counts, then runs it.
  task automatic instr(input string name, input logic [10:0] op, input logic z, input int fw,
                       input int mw, input int hc, input int e_cyc, input int e_pcw,
                       input int e_rw);
    int   k, b0, p0, r0;
    bit   faulted;
    logic taken, st;
    k = kind(op);
    st = (k == K_ST);
    lc = 0;
    cur_hc = hc;
    faulted = 1'b0;
    for (int i = 0; i < fw && i < TO; i++) put(1'b1, 1'b0, 1'b0, 1'b0, z, op, MRQ | BSY);
    if (fw >= TO) faulted = 1'b1;
    else put(1'b1, 1'b0, 1'b0, 1'b1, z, op, IRW | MRQ | BSY);
    if (!faulted) begin
      if (k == K_ILL) begin
        put(1'b1, 1'b0, 1'b0, 1'b0, z, op, RR | ILL | PCW | BSY);
      end else begin
        put(1'b1, 1'b0, 1'b0, 1'b0, z, op, RR | BSY);
        taken = (k == K_B) || (k == K_CBZ && z) || (k == K_CBNZ && !z);
        if (k >= K_B) put(1'b1, 1'b0, 1'b0, 1'b0, z, op, ALU | BSY | PCW | (taken ? PSRC : NONE));
        else          put(1'b1, 1'b0, 1'b0, 1'b0, z, op, ALU | BSY);
        if (k == K_LD || st) begin
          for (int i = 0; i < mw && i < TO; i++)
            put(1'b1, 1'b0, 1'b0, 1'b0, z, op, MRQ | BSY | (st ? MWE : NONE));
          if (mw >= TO) faulted = 1'b1;
          else put(1'b1, 1'b0, 1'b0, 1'b1, z, op, MRQ | BSY | (st ? (MWE | PCW) : NONE));
        end
        if (!faulted && (k == K_R || k == K_LD)) put(1'b1, 1'b0, 1'b0, 1'b0, z, op, RW | PCW | BSY);
      end
    end
    cur_hc = -1;
    b0 = busy_n; p0 = pcw_n; r0 = rw_n;
    run();
    pin({name, " busy cycles"}, longint'(busy_n - b0), longint'(e_cyc));
    pin({name, " PCWrite count"}, longint'(pcw_n - p0), longint'(e_pcw));
    pin({name, " RegWrite count"}, longint'(rw_n - r0), longint'(e_rw));
  endtask

  initial begin
    rst_n = 1'b0; Start = 1'b0; Halt = 1'b0; MemAck = 1'b0; Zero = 1'b0; Opcode = OP_ADD;

    // reset state
    put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OP_ADD, NONE);
    put(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, OP_ADD, NONE);
    run();

    // main instruction mix, 0-wait and delayed acks (limit-cycle ack included)
    idle(1, 1'b1);
    instr("ADD",            OP_ADD,  1'b0, 0, 0, -1, 4, 1, 1);
    instr("LDUR mw3",       OP_LDUR, 1'b0, 0, 3, -1, 8, 1, 1);
    instr("CBZ z1",         OP_CBZ,  1'b1, 0, 0, -1, 3, 1, 0);
    instr("CBNZ z1",        OP_CBNZ, 1'b1, 0, 0, -1, 3, 1, 0);
    instr("CBZ z0",         OP_CBZ,  1'b0, 0, 0, -1, 3, 1, 0);
    instr("CBNZ z0",        OP_CBNZ, 1'b0, 0, 0, -1, 3, 1, 0);
    instr("STUR fw2",       OP_STUR, 1'b0, 2, 0, -1, 6, 1, 0);
    instr("illegal",        OP_BAD,  1'b0, 0, 0, -1, 2, 1, 0);
    instr("B fw1",          OP_B,    1'b1, 1, 0, -1, 4, 1, 0);
    instr("SUB",            OP_SUB,  1'b0, 0, 0, -1, 4, 1, 1);
    instr("AND",            OP_AND,  1'b0, 0, 0, -1, 4, 1, 1);
    instr("ORR fw1",        OP_ORR,  1'b0, 1, 0, -1, 5, 1, 1);
    instr("ADD fw3 limit",  OP_ADD,  1'b0, 3, 0, -1, 7, 1, 1);
    instr("STUR halt in MEM", OP_STUR, 1'b0, 0, 2, 3, 6, 1, 0);
    idle(2, 1'b0);

    // Halt with Start in IDLE: Start wins and the halt is not kept
    put(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, OP_ADD, NONE);
    run();
    instr("ADD after start+halt", OP_ADD, 1'b0, 0, 0, -1, 4, 1, 1);
    instr("ADD halt in WB",       OP_ADD, 1'b0, 0, 0, 3, 4, 1, 1);
    idle(1, 1'b0);

    // fetch timeout, stray ack in FAULT, restart, then MEM timeout
    idle(1, 1'b1);
    instr("ADD fetch timeout", OP_ADD, 1'b0, TO, 0, -1, 4, 0, 0);
    put(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OP_ADD, FLT);
    put(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, OP_ADD, FLT);
    put(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OP_ADD, FLT);
    run();
    instr("ADD after fault", OP_ADD,  1'b0, 0, 0, -1, 4, 1, 1);
    instr("LDUR mem timeout", OP_LDUR, 1'b0, 0, TO, -1, 7, 0, 0);
    put(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OP_ADD, FLT);
    put(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OP_ADD, FLT);
    run();
    instr("ADD halt after fault", OP_ADD, 1'b0, 0, 0, 3, 4, 1, 1);
    idle(1, 1'b0);

    // reset while a load waits in MEM: MemReq drops the following cycle
    put(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OP_LDUR, NONE);
    put(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, OP_LDUR, IRW | MRQ | BSY);
    put(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OP_LDUR, RR | BSY);
    put(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OP_LDUR, ALU | BSY);
    put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OP_LDUR, MRQ | BSY);
    put(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, OP_LDUR, NONE);
    put(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OP_LDUR, NONE);
    run();

`ifdef SEQ_PERF_CNT_EN
    pin("CycleCnt after reset", longint'(CycleCnt), 0);
    pin("RetireCnt after reset", longint'(RetireCnt), 0);
    idle(1, 1'b1);
    instr("perf ADD1", OP_ADD, 1'b0, 0, 0, -1, 4, 1, 1);
    instr("perf ADD2", OP_ADD, 1'b0, 0, 0, -1, 4, 1, 1);
    instr("perf ADD3", OP_ADD, 1'b0, 0, 0, 3, 4, 1, 1);
    idle(1, 1'b0);
    pin("CycleCnt three ADDs", longint'(CycleCnt), 12);
    pin("RetireCnt three ADDs", longint'(RetireCnt), 3);
    put(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OP_ADD, NONE);
    put(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, OP_ADD, IRW | MRQ | BSY);
    put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OP_ADD, RR | BSY);
    put(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OP_ADD, NONE);
    run();
    pin("CycleCnt after mid-run reset", longint'(CycleCnt), 0);
    pin("RetireCnt after mid-run reset", longint'(RetireCnt), 0);
`endif

    // one more idle cycle lets queued count checks complete before the summary
    idle(1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
